// File: rtl/config_chain_loader.sv
// Multi-chain configuration loader: shifts a host-written image into NUM_CHAINS
// parallel scan chains under a divided programming clock, with optional readback verify.
module config_chain_loader #(
  parameter int NUM_CHAINS = 1,
  parameter int CHAIN_LEN  = 6140,
  parameter int CLK_DIV    = 2,
  localparam int AW        = $clog2(CHAIN_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [NUM_CHAINS-1:0] wr_data,
  input  logic                  start,
  input  logic                  verify_en,
  input  logic                  abort,
  output logic [NUM_CHAINS-1:0] chain_head,
  output logic                  prog_clk,
  input  logic [NUM_CHAINS-1:0] chain_tail,
  output logic                  busy,
  output logic                  done,
  output logic                  verify_err,
  output logic [AW:0]           err_count
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [AW-1:0] LAST_IDX = AW'(CHAIN_LEN - 1);
  localparam logic [PW-1:0] LAST_PH  = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] HIGH_PH  = PW'(CLK_DIV / 2);
  localparam logic [PW-1:0] CMP_PH   = PW'(CLK_DIV / 2 - 1);
  localparam logic [AW:0]   LEN_W    = (AW + 1)'(CHAIN_LEN);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, VERIFY} state_t;

  state_t                state, state_n;
  logic [AW-1:0]         bit_idx, bit_idx_n;
  logic [PW-1:0]         phase, phase_n;
  logic                  verify_lat, verify_lat_n;
  logic [NUM_CHAINS-1:0] head_n;
  logic                  pclk_n, busy_n, done_n, verr_n;
  logic [AW:0]           err_n;

  logic [NUM_CHAINS-1:0] image [CHAIN_LEN];
  logic [NUM_CHAINS-1:0] rd_data;
  logic [AW-1:0]         rd_addr;

  // Image RAM with a registered read port; the word for the next bit period is
  // prefetched while the current one is on the chain heads.
  always_ff @(posedge clk) begin
    if (state == IDLE && wr_en && {1'b0, wr_addr} < LEN_W)
      image[wr_addr] <= wr_data;
    rd_data <= image[rd_addr];
  end

  always_comb begin
    rd_addr = '0;
    if ((state == SHIFT || state == VERIFY) && bit_idx != LAST_IDX)
      rd_addr = bit_idx + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_idx    <= '0;
      phase      <= '0;
      verify_lat <= 1'b0;
      chain_head <= '0;
      prog_clk   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      verify_err <= 1'b0;
      err_count  <= '0;
    end else begin
      state      <= state_n;
      bit_idx    <= bit_idx_n;
      phase      <= phase_n;
      verify_lat <= verify_lat_n;
      chain_head <= head_n;
      prog_clk   <= pclk_n;
      busy       <= busy_n;
      done       <= done_n;
      verify_err <= verr_n;
      err_count  <= err_n;
    end
  end

  // FETCH spends two cycles so word 0 is through the RAM read register before bit 0.
  always_comb begin
    state_n      = state;
    bit_idx_n    = bit_idx;
    phase_n      = phase;
    verify_lat_n = verify_lat;
    head_n       = chain_head;
    pclk_n       = prog_clk;
    busy_n       = busy;
    done_n       = done;
    verr_n       = verify_err;
    err_n        = err_count;
    if (abort) begin
      state_n   = IDLE;
      bit_idx_n = '0;
      phase_n   = '0;
      head_n    = '0;
      pclk_n    = 1'b0;
      busy_n    = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state_n      = FETCH;
            bit_idx_n    = '0;
            phase_n      = '0;
            verify_lat_n = verify_en;
            busy_n       = 1'b1;
            done_n       = 1'b0;
            verr_n       = 1'b0;
            err_n        = '0;
          end
        end
        FETCH: begin
          if (phase == '0) begin
            phase_n = phase + 1'b1;
          end else begin
            state_n   = SHIFT;
            bit_idx_n = '0;
            phase_n   = '0;
            head_n    = rd_data;
            pclk_n    = 1'b0;
          end
        end
        SHIFT, VERIFY: begin
          // Readback is sampled just before prog_clk rises, while the tail still holds bit k.
          if (state == VERIFY && phase == CMP_PH && chain_tail != chain_head) begin
            verr_n = 1'b1;
            if (err_count != '1)
              err_n = err_count + 1'b1;
          end
          if (phase != LAST_PH) begin
            phase_n = phase + 1'b1;
            pclk_n  = ((phase + 1'b1) >= HIGH_PH);
          end else begin
            phase_n = '0;
            pclk_n  = 1'b0;
            if (bit_idx != LAST_IDX) begin
              bit_idx_n = bit_idx + 1'b1;
              head_n    = rd_data;
            end else if (state == SHIFT && verify_lat) begin
              state_n   = VERIFY;
              bit_idx_n = '0;
              head_n    = rd_data;
            end else begin
              state_n   = IDLE;
              bit_idx_n = '0;
              head_n    = '0;
              busy_n    = 1'b0;
              done_n    = 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader: a 4-chain DUT with modelled shift-register chains
// and a 1-chain DUT at a slower divider, both checked through head-word scoreboards.
module tb_config_chain_loader;

  localparam int NA = 4;
  localparam int LA = 12;
  localparam int DA = 2;
  localparam int LB = 8;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rst;

  logic          wr_en_a, start_a, verify_en_a, abort_a;
  logic [3:0]    wr_addr_a;
  logic [NA-1:0] wr_data_a, chain_head_a, chain_tail_a, fault_mask;
  logic          prog_clk_a, busy_a, done_a, verify_err_a;
  logic [4:0]    err_count_a;

  logic          wr_en_b, start_b, verify_en_b, abort_b;
  logic [2:0]    wr_addr_b;
  logic [0:0]    wr_data_b, chain_head_b, chain_tail_b;
  logic          prog_clk_b, busy_b, done_b, verify_err_b;
  logic [3:0]    err_count_b;

  int            n_compared = 0;
  int            n_mismatch = 0;
  logic [NA-1:0] exp_a [$];
  logic          exp_b [$];
  int            rises_a = 0;
  int            rises_b = 0;
  int            rise_base = 0;
  logic          pclk_prev_a = 1'b0;
  logic          pclk_prev_b = 1'b0;
  logic          inject_on = 1'b0;
  logic [LA-1:0] chain_a [NA] = '{default: '0};
  logic [NA-1:0] img_a [LA];
  logic          img_b [LB];
  logic [7:0]    pat_b = 8'b10110010;

  always #5 clk = ~clk;

  config_chain_loader #(.NUM_CHAINS(NA), .CHAIN_LEN(LA), .CLK_DIV(DA)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .start(start_a), .verify_en(verify_en_a), .abort(abort_a), .chain_head(chain_head_a),
    .prog_clk(prog_clk_a), .chain_tail(chain_tail_a), .busy(busy_a), .done(done_a),
    .verify_err(verify_err_a), .err_count(err_count_a)
  );

  config_chain_loader #(.NUM_CHAINS(1), .CHAIN_LEN(LB), .CLK_DIV(DB)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .start(start_b), .verify_en(verify_en_b), .abort(abort_b), .chain_head(chain_head_b),
    .prog_clk(prog_clk_b), .chain_tail(chain_tail_b), .busy(busy_b), .done(done_b),
    .verify_err(verify_err_b), .err_count(err_count_b)
  );

  // Chain model: each chain is an LA-stage shift register clocked by prog_clk.
  always @(posedge prog_clk_a)
    for (int c = 0; c < NA; c++) chain_a[c] <= {chain_a[c][LA-2:0], chain_head_a[c]};

  assign fault_mask = (inject_on && (rises_a - rise_base) >= 13 && (rises_a - rise_base) <= 15)
                      ? 4'b0100 : 4'b0000;
  assign chain_tail_a = {chain_a[3][LA-1], chain_a[2][LA-1], chain_a[1][LA-1], chain_a[0][LA-1]}
                        ^ fault_mask;
  assign chain_tail_b = 1'b0;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_compared++;
    assert (observed === expected)
      else begin
        n_mismatch++;
        $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  // Every prog_clk rise consumes one expected head word.
  always @(negedge clk) begin
    if (prog_clk_a && !pclk_prev_a) begin
      rises_a++;
      check_output("sb_a_nonempty", 32'(exp_a.size() > 0), 32'd1);
      if (exp_a.size() > 0) check_output("head_a", 32'(chain_head_a), 32'(exp_a.pop_front()));
    end
    pclk_prev_a = prog_clk_a;
    if (prog_clk_b && !pclk_prev_b) begin
      rises_b++;
      check_output("sb_b_nonempty", 32'(exp_b.size() > 0), 32'd1);
      if (exp_b.size() > 0) check_output("head_b", 32'(chain_head_b), 32'(exp_b.pop_front()));
    end
    pclk_prev_b = prog_clk_b;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input bit sel_b, input logic ver);
    if (sel_b) begin start_b = 1'b1; verify_en_b = ver; end
    else       begin start_a = 1'b1; verify_en_a = ver; end
    step();
    start_a = 1'b0; start_b = 1'b0; verify_en_a = 1'b0; verify_en_b = 1'b0;
  endtask

  task automatic push_image_a(input int passes, input int words);
    for (int p = 0; p < passes; p++)
      for (int k = 0; k < words; k++) exp_a.push_back(img_a[k]);
  endtask

  task automatic wait_done(input bit sel_b, input int from, input int budget, output int cyc);
    cyc = from;
    while (!(sel_b ? done_b : done_a) && cyc < budget) begin
      step();
      cyc++;
    end
    check_output(sel_b ? "done_b_wait" : "done_a_wait", 32'(sel_b ? done_b : done_a), 32'd1);
  endtask

  task automatic wait_rises_a(input int target, input int budget);
    int n = 0;
    while ((rises_a - rise_base) < target && n < budget) begin
      step();
      n++;
    end
    check_output("rises_a_wait", 32'(rises_a - rise_base), 32'(target));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc;
    int rb;
    rst = 1'b1;
    {wr_en_a, start_a, verify_en_a, abort_a, wr_addr_a, wr_data_a} = '0;
    {wr_en_b, start_b, verify_en_b, abort_b, wr_addr_b, wr_data_b} = '0;
    for (int k = 0; k < LA; k++) img_a[k] = 4'((k * 11 + 5) % 16);
    for (int k = 0; k < LB; k++) img_b[k] = pat_b[7 - k];
    step(3);
    check_output("reset_a", 32'({chain_head_a, prog_clk_a, busy_a, done_a, verify_err_a, err_count_a}), 32'd0);
    check_output("reset_b", 32'({chain_head_b, prog_clk_b, busy_b, done_b, verify_err_b, err_count_b}), 32'd0);
    rst = 1'b0;
    step(2);

    $display("[TB] writing images");
    for (int k = 0; k < LA; k++) begin
      wr_en_a = 1'b1; wr_addr_a = 4'(k); wr_data_a = img_a[k];
      if (k < LB) begin wr_en_b = 1'b1; wr_addr_b = 3'(k); wr_data_b = img_b[k]; end
      else wr_en_b = 1'b0;
      step();
    end
    wr_en_a = 1'b0; wr_en_b = 1'b0;
    step();

    $display("[TB] load A, no verify");
    rise_base = rises_a;
    push_image_a(1, LA);
    apply_stimulus(1'b0, 1'b0);
    check_output("busy_after_start_a", 32'(busy_a), 32'd1);
    wait_done(1'b0, 0, 200, cyc);
    check_output("done_latency_a", 32'(cyc), 32'(2 + LA * DA));
    check_output("idle_outputs_a", 32'({busy_a, prog_clk_a, chain_head_a}), 32'd0);
    check_output("rises_load_a", 32'(rises_a - rise_base), 32'(LA));

    $display("[TB] load B, pattern 10110010 with divider 4");
    rb = rises_b;
    for (int k = 0; k < LB; k++) exp_b.push_back(img_b[k]);
    apply_stimulus(1'b1, 1'b0);
    step();
    check_output("fetch_b", 32'({busy_b, chain_head_b}), 32'b10);
    step();
    check_output("first_bit_b", 32'(chain_head_b), 32'(img_b[0]));
    for (int p = 0; p < DB; p++) begin
      check_output("pclk_shape_b", 32'(prog_clk_b), 32'(p >= DB / 2));
      step();
    end
    check_output("second_bit_b", 32'(chain_head_b), 32'(img_b[1]));
    wait_done(1'b1, 2 + DB, 300, cyc);
    check_output("done_latency_b", 32'(cyc), 32'(2 + LB * DB));
    check_output("idle_outputs_b", 32'({busy_b, prog_clk_b, chain_head_b}), 32'd0);
    check_output("rises_load_b", 32'(rises_b - rb), 32'(LB));

    $display("[TB] load A with clean verify");
    rise_base = rises_a;
    push_image_a(2, LA);
    apply_stimulus(1'b0, 1'b1);
    wait_done(1'b0, 0, 300, cyc);
    check_output("rises_verify_a", 32'(rises_a - rise_base), 32'(2 * LA));
    check_output("err_clean_a", 32'({verify_err_a, err_count_a}), 32'd0);

    $display("[TB] load A with verify and injected tail faults");
    rise_base = rises_a;
    inject_on = 1'b1;
    push_image_a(2, LA);
    apply_stimulus(1'b0, 1'b1);
    wait_done(1'b0, 0, 300, cyc);
    inject_on = 1'b0;
    check_output("err_count_fault_a", 32'(err_count_a), 32'd3);
    check_output("verify_err_fault_a", 32'(verify_err_a), 32'd1);

    $display("[TB] abort A at bit 5, then reload");
    rise_base = rises_a;
    push_image_a(1, 5);
    apply_stimulus(1'b0, 1'b0);
    wait_rises_a(5, 100);
    step();
    check_output("bit5_head_a", 32'({chain_head_a, prog_clk_a}), 32'({img_a[5], 1'b0}));
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    check_output("abort_outputs_a", 32'({busy_a, prog_clk_a, chain_head_a, done_a}), 32'd0);
    step(6);
    check_output("abort_no_rises_a", 32'(rises_a - rise_base), 32'd5);
    rise_base = rises_a;
    push_image_a(1, LA);
    apply_stimulus(1'b0, 1'b0);
    wait_done(1'b0, 0, 200, cyc);
    check_output("reload_latency_a", 32'(cyc), 32'(2 + LA * DA));
    check_output("reload_rises_a", 32'(rises_a - rise_base), 32'(LA));

    $display("[TB] protocol: write and start while busy, out-of-range write");
    rise_base = rises_a;
    push_image_a(1, LA);
    apply_stimulus(1'b0, 1'b0);
    step(3);
    wr_en_a = 1'b1; wr_addr_a = 4'd3; wr_data_a = ~img_a[3]; start_a = 1'b1;
    step();
    wr_en_a = 1'b0; start_a = 1'b0;
    wait_done(1'b0, 4, 200, cyc);
    check_output("busy_start_latency_a", 32'(cyc), 32'(2 + LA * DA));
    wr_en_a = 1'b1; wr_addr_a = 4'(LA); wr_data_a = 4'hF;
    step();
    wr_en_a = 1'b0;
    rise_base = rises_a;
    push_image_a(1, LA);
    apply_stimulus(1'b0, 1'b0);
    wait_done(1'b0, 0, 200, cyc);
    check_output("protocol_rises_a", 32'(rises_a - rise_base), 32'(LA));
    check_output("protocol_sb_empty_a", 32'(exp_a.size()), 32'd0);

    $display("[TB] reset during shift");
    rise_base = rises_a;
    push_image_a(1, LA);
    apply_stimulus(1'b0, 1'b0);
    wait_rises_a(4, 100);
    #2 rst = 1'b1;
    #1;
    check_output("async_reset_a", 32'({chain_head_a, prog_clk_a, busy_a, done_a, verify_err_a, err_count_a}), 32'd0);
    step(2);
    rst = 1'b0;
    exp_a.delete();
    rb = rises_a;
    step(20);
    check_output("post_reset_rises_a", 32'(rises_a - rb), 32'd0);
    check_output("post_reset_busy_a", 32'(busy_a), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
